arrow_spawner: RTL and testbench

- Upstream sequencer for the arrow renderer.
- Generates the per-arrow command bundle (valid, direction, speed, inversed) that the renderer consumes. Each arrow is one valid-high window, and successive arrows are separated by a low gap so the renderer sees a fresh rising edge.
- All timing is counted in video frames, derived from the hcount/vcount origin. Pseudo-random arrow attributes come from a seeded 16-bit LFSR, which makes sequences deterministic.

---
 rtl/arrow_pkg.sv | 42 ++++
 rtl/lfsr16.sv | 35 +++
 rtl/arrow_spawner.sv | 159 +++++++++++++++
 tb/tb_arrow_spawner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arrow_pkg
// Description : Shared types, constants and helpers for the arrow spawner.
//               Direction encoding, FSM state encoding, the LFSR polynomial
//               and the speed-code mapping live here so the spawner and the
//               LFSR agree on them.
// Revision    : 1.0 - initial release
// ============================================================================
package arrow_pkg;

  typedef enum logic [1:0] {
    DIR_TOP    = 2'b00,
    DIR_BOTTOM = 2'b01,
    DIR_LEFT   = 2'b10,
    DIR_RIGHT  = 2'b11
  } direction_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT  = 16'hACE1;
  localparam int          ARROW_STEP_PX = 4;
  localparam int          CENTER_X      = 512;
  localparam int          CENTER_Y      = 384;

  // One Galois step, shifting right with feedback from bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Speed code 0 would freeze an arrow, so it is promoted to 1.
  function automatic logic [2:0] speed_code(input logic [2:0] raw);
    return (raw == 3'd0) ? 3'd1 : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Galois LFSR that steps only when asked to.
//               A zero load value would lock the register at zero, so it is
//               replaced by the package default.
// Ports       : clk     in   clock
//               rst     in   asynchronous active-high reset
//               advance in   take one Galois step on this clock
//               state   out  current LFSR contents
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
  import arrow_pkg::*;
#(
  parameter logic [15:0] LOAD_VALUE = LFSR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] state
);

  localparam logic [15:0] RESET_VALUE = (LOAD_VALUE == 16'h0000) ? LFSR_DEFAULT : LOAD_VALUE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_VALUE;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule
`default_nettype wire

// File: rtl/arrow_spawner.sv
`default_nettype none
// ============================================================================
// Module      : arrow_spawner
// Description : Sequencer producing one command bundle per arrow for the
//               arrow renderer. Arrows alternate with low gaps; all timing
//               is counted in frames (hcount/vcount origin). Attributes are
//               drawn from a seeded LFSR that steps once per spawn.
// Ports       : clk             in   pixel clock
//               rst             in   asynchronous active-high reset
//               hcount_in[10:0] in   current pixel column
//               vcount_in[9:0]  in   current pixel row
//               enable_in       in   game running; low forces IDLE
//               valid_out       out  arrow alive
//               direction_out   out  00 top, 01 bottom, 10 left, 11 right
//               speed_out[2:0]  out  speed code 1..7
//               inversed_out    out  inversed-arrow flag
//               spawn_count_out out  arrows launched, modulo 256
// Revision    : 1.0 - initial release
// ============================================================================
module arrow_spawner
  import arrow_pkg::*;
#(
  parameter int          GAP_FRAMES   = 30,
  parameter int          VERT_FRAMES  = 100,
  parameter int          HORIZ_FRAMES = 132,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        enable_in,
  output logic        valid_out,
  output logic [1:0]  direction_out,
  output logic [2:0]  speed_out,
  output logic        inversed_out,
  output logic [7:0]  spawn_count_out
);

  // The frame counter is 8 bits wide, so every frame count must fit 1..256.
  if (GAP_FRAMES < 1 || GAP_FRAMES > 256 ||
      VERT_FRAMES < 1 || VERT_FRAMES > 256 ||
      HORIZ_FRAMES < 1 || HORIZ_FRAMES > 256) begin : g_param_check
    $error("arrow_spawner: frame parameters must lie in 1..256");
  end

  localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);
  localparam logic [7:0] VERT_LAST  = 8'(VERT_FRAMES - 1);
  localparam logic [7:0] HORIZ_LAST = 8'(HORIZ_FRAMES - 1);

  state_t      state, state_nxt;
  logic [7:0]  frame_cnt, frame_cnt_nxt;
  logic        valid_nxt;
  logic [1:0]  dir_nxt;
  logic [2:0]  speed_nxt;
  logic        inv_nxt;
  logic [7:0]  count_nxt;
  logic        lfsr_advance;
  logic [15:0] lfsr_state;
  logic        tick;
  logic [7:0]  life_last;
  logic        unused_lfsr_bits;

  lfsr16 #(
    .LOAD_VALUE (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (lfsr_advance),
    .state   (lfsr_state)
  );

  assign tick             = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  // Horizontal arrows travel further, so their window is longer.
  assign life_last        = direction_out[1] ? HORIZ_LAST : VERT_LAST;
  assign unused_lfsr_bits = &{1'b0, lfsr_state[15:8], lfsr_state[3:2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      frame_cnt       <= 8'd0;
      valid_out       <= 1'b0;
      direction_out   <= 2'b00;
      speed_out       <= 3'd0;
      inversed_out    <= 1'b0;
      spawn_count_out <= 8'd0;
    end else begin
      state           <= state_nxt;
      frame_cnt       <= frame_cnt_nxt;
      valid_out       <= valid_nxt;
      direction_out   <= dir_nxt;
      speed_out       <= speed_nxt;
      inversed_out    <= inv_nxt;
      spawn_count_out <= count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    valid_nxt     = valid_out;
    dir_nxt       = direction_out;
    speed_nxt     = speed_out;
    inv_nxt       = inversed_out;
    count_nxt     = spawn_count_out;
    lfsr_advance  = 1'b0;

    if (!enable_in) begin
      // Abort any arrow in flight; LFSR and spawn count are kept.
      state_nxt     = IDLE;
      frame_cnt_nxt = 8'd0;
      valid_nxt     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt     = GAP;
          frame_cnt_nxt = 8'd0;
          valid_nxt     = 1'b0;
        end
        GAP: begin
          valid_nxt = 1'b0;
          if (tick) begin
            if (frame_cnt == GAP_LAST) begin
              state_nxt     = ACTIVE;
              frame_cnt_nxt = 8'd0;
              valid_nxt     = 1'b1;
              dir_nxt       = lfsr_state[1:0];
              inv_nxt       = lfsr_state[4];
              speed_nxt     = speed_code(lfsr_state[7:5]);
              count_nxt     = spawn_count_out + 8'd1;
              lfsr_advance  = 1'b1;
            end else begin
              frame_cnt_nxt = frame_cnt + 8'd1;
            end
          end
        end
        ACTIVE: begin
          valid_nxt = 1'b1;
          if (tick) begin
            if (frame_cnt == life_last) begin
              state_nxt     = GAP;
              frame_cnt_nxt = 8'd0;
              valid_nxt     = 1'b0;
            end else begin
              frame_cnt_nxt = frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_nxt     = IDLE;
          frame_cnt_nxt = 8'd0;
          valid_nxt     = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arrow_spawner.sv
`default_nettype none
// ============================================================================
// Module      : tb_arrow_spawner
// Description : Directed self-checking bench for arrow_spawner. Three
//               instances share clock, reset and frame counters:
//               A (GAP=2, VERT=3, HORIZ=5, seed ACE1) for launch, lifetime,
//               abort and reset; B (same timing, seed 0002) for a horizontal
//               arrow; C (all frame counts 1) for spawn-count wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arrow_spawner;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        en_a, en_b, en_c;

  logic        valid_a, valid_b, valid_c;
  logic [1:0]  dir_a, dir_b, dir_c;
  logic [2:0]  speed_a, speed_b, speed_c;
  logic        inv_a, inv_b, inv_c;
  logic [7:0]  count_a, count_b, count_c;

  int n_vec = 0;
  int n_err = 0;

  arrow_spawner #(
    .GAP_FRAMES(2), .VERT_FRAMES(3), .HORIZ_FRAMES(5), .SEED(16'hACE1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
    .enable_in(en_a), .valid_out(valid_a), .direction_out(dir_a),
    .speed_out(speed_a), .inversed_out(inv_a), .spawn_count_out(count_a)
  );

  arrow_spawner #(
    .GAP_FRAMES(2), .VERT_FRAMES(3), .HORIZ_FRAMES(5), .SEED(16'h0002)
  ) u_dut_b (
    .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
    .enable_in(en_b), .valid_out(valid_b), .direction_out(dir_b),
    .speed_out(speed_b), .inversed_out(inv_b), .spawn_count_out(count_b)
  );

  arrow_spawner #(
    .GAP_FRAMES(1), .VERT_FRAMES(1), .HORIZ_FRAMES(1), .SEED(16'hACE1)
  ) u_dut_c (
    .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
    .enable_in(en_c), .valid_out(valid_c), .direction_out(dir_c),
    .speed_out(speed_c), .inversed_out(inv_c), .spawn_count_out(count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; t=1 presents the frame origin so that edge is a tick.
  // Returns 1 time unit after the rising edge.
  task automatic step(input bit t);
    @(negedge clk);
    if (t) begin
      hcount = 11'd0;
      vcount = 10'd0;
    end else begin
      hcount = 11'd7;
      vcount = 10'd3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic v, input logic [1:0] d,
                         input logic i, input logic [2:0] s, input logic [7:0] c);
    check_val({tag, "_valid"}, 16'(valid_a), 16'(v));
    check_val({tag, "_dir"},   16'(dir_a),   16'(d));
    check_val({tag, "_inv"},   16'(inv_a),   16'(i));
    check_val({tag, "_speed"}, 16'(speed_a), 16'(s));
    check_val({tag, "_count"}, 16'(count_a), 16'(c));
  endtask

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    hcount = 11'd7; vcount = 10'd3;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check_a("rst_a", 1'b0, 2'b00, 1'b0, 3'd0, 8'd0);
    check_val("rst_b_valid", 16'(valid_b), 16'd0);
    check_val("rst_c_count", 16'(count_c), 16'd0);

    // First arrow after reset: one gap tick, then launch with seed ACE1
    en_a = 1'b1; rst = 1'b0;
    step(0);
    check_val("idle2gap_valid", 16'(valid_a), 16'd0);
    step(1);
    check_val("gap_tick1_valid", 16'(valid_a), 16'd0);
    step(1);
    check_a("arrow1", 1'b1, 2'b01, 1'b0, 3'd7, 8'd1);

    // Lifetime of 3 ticks for a vertical arrow; non-tick clocks do nothing
    step(0);
    check_val("a1_notick_valid", 16'(valid_a), 16'd1);
    step(1);
    check_val("a1_tick2_valid", 16'(valid_a), 16'd1);
    step(1);
    check_val("a1_tick3_valid", 16'(valid_a), 16'd1);
    step(1);
    check_val("a1_end_valid", 16'(valid_a), 16'd0);
    check_val("a1_end_dir_hold", 16'(dir_a), 16'd1);
    step(1);
    check_val("gap2_tick1_valid", 16'(valid_a), 16'd0);
    step(1);
    check_a("arrow2", 1'b1, 2'b00, 1'b1, 3'd3, 8'd2);

    // Abort mid-flight with enable low
    step(1);
    check_val("a2_tick2_valid", 16'(valid_a), 16'd1);
    en_a = 1'b0;
    step(0);
    check_val("abort_valid", 16'(valid_a), 16'd0);
    check_val("abort_count", 16'(count_a), 16'd2);
    step(1);
    check_val("idle_tick_valid", 16'(valid_a), 16'd0);
    en_a = 1'b1;
    step(0);
    check_val("reen_valid", 16'(valid_a), 16'd0);
    step(1);
    check_val("reen_gap_valid", 16'(valid_a), 16'd0);
    check_val("reen_gap_count", 16'(count_a), 16'd2);
    step(1);
    check_a("arrow3", 1'b1, 2'b00, 1'b1, 3'd1, 8'd3);

    // Asynchronous reset between edges during ACTIVE
    step(1);
    check_val("a3_tick2_valid", 16'(valid_a), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check_a("async_rst", 1'b0, 2'b00, 1'b0, 3'd0, 8'd0);
    #1;
    rst = 1'b0;
    step(0);
    step(1);
    check_val("rerun_gap_valid", 16'(valid_a), 16'd0);
    step(1);
    check_a("rerun_arrow1", 1'b1, 2'b01, 1'b0, 3'd7, 8'd1);
    en_a = 1'b0;

    // Horizontal arrow from seed 0002: direction 10, speed promoted to 1
    en_b = 1'b1;
    step(0);
    step(1);
    check_val("b_gap_valid", 16'(valid_b), 16'd0);
    step(1);
    check_val("b_launch_valid", 16'(valid_b), 16'd1);
    check_val("b_launch_dir",   16'(dir_b),   16'd2);
    check_val("b_launch_inv",   16'(inv_b),   16'd0);
    check_val("b_launch_speed", 16'(speed_b), 16'd1);
    check_val("b_launch_count", 16'(count_b), 16'd1);
    for (int k = 2; k <= 5; k++) begin
      step(1);
      check_val($sformatf("b_tick%0d_valid", k), 16'(valid_b), 16'd1);
    end
    step(1);
    check_val("b_end_valid", 16'(valid_b), 16'd0);
    en_b = 1'b0;

    // 256 one-frame arrows with one-frame gaps: count wraps to zero
    en_c = 1'b1;
    step(0);
    for (int i = 1; i <= 256; i++) begin
      step(1);
      check_val($sformatf("c_spawn%0d_valid", i), 16'(valid_c), 16'd1);
      check_val($sformatf("c_spawn%0d_count", i), 16'(count_c), 16'(i % 256));
      step(1);
      check_val($sformatf("c_gap%0d_valid", i), 16'(valid_c), 16'd0);
    end
    check_val("c_wrap_count", 16'(count_c), 16'd0);
    en_c = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
